// File: rtl/botones_mascota_pkg.sv
// ---------------------------------------------------------------------------
// botones_pkg
// Shared definitions for the virtual-pet button front end:
//   - deb_state_e : 2-bit debounce FSM state encoding
//   - HCNT_W      : width of the long-press hold counters
//   - IDX_*       : slot of each board input in the per-input vectors
//   - is_stable_high() : stable level implied by a debounce state
// ---------------------------------------------------------------------------
package botones_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,  // stable 0
    RISE_WAIT = 2'd1,  // saw a 1, confirming
    HELD      = 2'd2,  // stable 1
    FALL_WAIT = 2'd3   // saw a 0, confirming
  } deb_state_e;

  localparam int HCNT_W     = 4;
  localparam int NUM_INPUTS = 5;

  localparam int IDX_TEST     = 0;
  localparam int IDX_COMIDA   = 1;
  localparam int IDX_MEDICINA = 2;
  localparam int IDX_CARINO   = 3;
  localparam int IDX_DORMIR   = 4;

  function automatic logic is_stable_high(input deb_state_e st);
    return (st == HELD) || (st == FALL_WAIT);
  endfunction

endpackage

// File: rtl/botones_mascota_if.sv
// ---------------------------------------------------------------------------
// botones_mascota_if
// Bundle between the board pins / pet core and the button front end.
//   Board side (into the block): test, Dormir, Comida, Medicina, Carino
//   Core side (out of the block): test_lvl, comida_pulse, medicina_pulse,
//     carino_hold, dormir_hold, carino_long, dormir_long
//   Debug: dbg_state[i] is the debounce FSM state of input slot i (IDX_*).
// Handshake: there is no valid/ready pair here. Inputs are free-running raw
// levels; *_hold/test_lvl are levels and *_pulse/*_long are single-cycle
// events that the consumer must sample every clock (no back-pressure).
// ---------------------------------------------------------------------------
interface botones_mascota_if;
  import botones_pkg::*;

  logic test;
  logic Dormir;
  logic Comida;
  logic Medicina;
  logic Carino;

  logic test_lvl;
  logic comida_pulse;
  logic medicina_pulse;
  logic carino_hold;
  logic dormir_hold;
  logic carino_long;
  logic dormir_long;

  logic [NUM_INPUTS-1:0][1:0] dbg_state;

  // master drives the raw pins and consumes the conditioned signals
  modport master (
    output test, Dormir, Comida, Medicina, Carino,
    input  test_lvl, comida_pulse, medicina_pulse,
    input  carino_hold, dormir_hold, carino_long, dormir_long,
    input  dbg_state
  );

  // slave is the front end itself
  modport slave (
    input  test, Dormir, Comida, Medicina, Carino,
    output test_lvl, comida_pulse, medicina_pulse,
    output carino_hold, dormir_hold, carino_long, dormir_long,
    output dbg_state
  );

endinterface

// File: rtl/botones_mascota_debounce_fsm.sv
// ---------------------------------------------------------------------------
// debounce_fsm
// 2-flop synchronizer followed by a 4-state debounce FSM for one raw input.
//   clk, reset : system clock, synchronous active-high reset
//   raw_i      : asynchronous raw pin
//   level_o    : debounced stable level (1 in HELD/FALL_WAIT)
//   rise_o     : one-clock registered flag on the RISE_WAIT->HELD transition
//   state_o    : current FSM state (debug)
// A new stable level is adopted only after the synchronized input has
// disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
// ---------------------------------------------------------------------------
module debounce_fsm
  import botones_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_i,
  output logic       level_o,
  output logic       rise_o,
  output deb_state_e state_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  deb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rise_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // The counter is cleared on every state exit, so it never wraps; the
  // >= compare only guards the degenerate DEBOUNCE_CYCLES==1 build.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sync2_q) begin
            state_q <= RISE_WAIT;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        RISE_WAIT: begin
          if (!sync2_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q >= CNT_LAST) begin
            state_q <= HELD;
            cnt_q   <= '0;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          if (!sync2_q) begin
            state_q <= FALL_WAIT;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        FALL_WAIT: begin
          if (sync2_q) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q >= CNT_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o = is_stable_high(state_q);
  assign rise_o  = rise_q;
  assign state_o = state_q;

endmodule

// File: rtl/botones_mascota.sv
// ---------------------------------------------------------------------------
// botones_mascota
// Input-conditioning front end for the virtual-pet core.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : botones_mascota_if.slave (raw pins in, conditioned signals out)
// Five debounce_fsm instances clean up the raw pins. Comida/Medicina expose
// their press flag; Carino/Dormir expose their level plus a long-press pulse
// every LONG_PRESS_TICKS ticks of continuous hold. A debounced test switch
// turns every clock into a tick so long presses can be exercised quickly.
// ---------------------------------------------------------------------------
module botones_mascota
  import botones_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int TICK_CYCLES      = 5,
  parameter int LONG_PRESS_TICKS = 15
) (
  input logic               clk,
  input logic               reset,
  botones_mascota_if.slave  bus
);

  localparam int TCNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_PRESS_TICKS - 1);
  localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);

  logic [NUM_INPUTS-1:0] raw;
  logic [NUM_INPUTS-1:0] level;
  logic [NUM_INPUTS-1:0] rise;
  deb_state_e            state [NUM_INPUTS];

  assign raw[IDX_TEST]     = bus.test;
  assign raw[IDX_COMIDA]   = bus.Comida;
  assign raw[IDX_MEDICINA] = bus.Medicina;
  assign raw[IDX_CARINO]   = bus.Carino;
  assign raw[IDX_DORMIR]   = bus.Dormir;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_deb
    debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (raw[g]),
      .level_o (level[g]),
      .rise_o  (rise[g]),
      .state_o (state[g])
    );
    assign bus.dbg_state[g] = state[g];
  end

  // Tick generator: free-running divider, frozen at 0 while in test mode
  // where every clock counts as a tick.
  logic [TCNT_W-1:0] tcnt_q;
  logic              tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q <= '0;
    end else if (level[IDX_TEST] || (tcnt_q == TCNT_LAST)) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_q + TCNT_ONE;
    end
  end

  assign tick = level[IDX_TEST] || (tcnt_q == TCNT_LAST);

  // Hold counters: slot 0 = Carino, slot 1 = Dormir.
  logic [1:0]        hold_lvl;
  logic [HCNT_W-1:0] hcnt_q [2];
  logic [1:0]        long_q;

  assign hold_lvl = {level[IDX_DORMIR], level[IDX_CARINO]};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int h = 0; h < 2; h++) begin
        hcnt_q[h] <= '0;
        long_q[h] <= 1'b0;
      end
    end else begin
      for (int h = 0; h < 2; h++) begin
        long_q[h] <= 1'b0;
        if (!hold_lvl[h]) begin
          hcnt_q[h] <= '0;
        end else if (tick) begin
          if (hcnt_q[h] == HCNT_LAST) begin
            hcnt_q[h] <= '0;
            long_q[h] <= 1'b1;
          end else begin
            hcnt_q[h] <= hcnt_q[h] + HCNT_ONE;
          end
        end
      end
    end
  end

  assign bus.test_lvl       = level[IDX_TEST];
  assign bus.comida_pulse   = rise[IDX_COMIDA];
  assign bus.medicina_pulse = rise[IDX_MEDICINA];
  assign bus.carino_hold    = level[IDX_CARINO];
  assign bus.dormir_hold    = level[IDX_DORMIR];
  // A long pulse computed on the same edge the button finishes releasing
  // would otherwise appear in the first cycle with the hold already low.
  assign bus.carino_long    = long_q[0] & level[IDX_CARINO];
  assign bus.dormir_long    = long_q[1] & level[IDX_DORMIR];

endmodule

// File: tb/tb_botones_mascota.sv
// ---------------------------------------------------------------------------
// tb_botones_mascota
// Drives the raw pins at the falling edge, samples outputs at the falling
// edge, and compares every cycle against a behavioural model built from the
// pin-level rules: 2-clock synchronizer delay, "flip after N consecutive
// disagreements", tick divider, and long pulse every LP ticks of hold.
// Output vector order: {test_lvl, comida_pulse, medicina_pulse,
//                       carino_hold, dormir_hold, carino_long, dormir_long}
// ---------------------------------------------------------------------------
module tb_botones_mascota;

  localparam int DC = 4;
  localparam int TC = 5;
  localparam int LP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  botones_mascota_if bif ();

  botones_mascota #(
    .DEBOUNCE_CYCLES (DC),
    .TICK_CYCLES     (TC),
    .LONG_PRESS_TICKS(LP)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bif)
  );

  logic [6:0] dut_vec;
  assign dut_vec = {bif.test_lvl, bif.comida_pulse, bif.medicina_pulse,
                    bif.carino_hold, bif.dormir_hold, bif.carino_long,
                    bif.dormir_long};

  // ---------------- reference model ----------------
  // slots: 0 test, 1 comida, 2 medicina, 3 carino, 4 dormir
  bit m_d1  [5];
  bit m_d2  [5];
  bit m_lvl [5];
  int m_run [5];
  bit m_rise[5];
  int m_tph;
  int m_ticks[2];
  bit m_long [2];

  function automatic bit raw_pin(input int i);
    case (i)
      0:       return bif.test;
      1:       return bif.Comida;
      2:       return bif.Medicina;
      3:       return bif.Carino;
      default: return bif.Dormir;
    endcase
  endfunction

  task automatic model_edge();
    bit tick;
    bit seen;
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        m_d1[i] = 0; m_d2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_rise[i] = 0;
      end
      m_tph = 0;
      for (int h = 0; h < 2; h++) begin m_ticks[h] = 0; m_long[h] = 0; end
      return;
    end
    tick  = m_lvl[0] || (m_tph == TC - 1);
    m_tph = m_lvl[0] ? 0 : (m_tph + 1) % TC;
    for (int h = 0; h < 2; h++) begin
      m_long[h] = 0;
      if (!m_lvl[3 + h]) m_ticks[h] = 0;
      else if (tick) begin
        m_ticks[h]++;
        if (m_ticks[h] == LP) begin
          m_long[h]  = 1;
          m_ticks[h] = 0;
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      seen      = m_d2[i];
      m_rise[i] = 0;
      if (seen != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DC) begin
          m_lvl[i]  = seen;
          m_run[i]  = 0;
          m_rise[i] = seen;
        end
      end else begin
        m_run[i] = 0;
      end
      m_d2[i] = m_d1[i];
      m_d1[i] = raw_pin(i);
    end
  endtask

  function automatic logic [6:0] exp_vec();
    return {m_lvl[0], m_rise[1], m_rise[2], m_lvl[3], m_lvl[4],
            m_long[0] & m_lvl[3], m_long[1] & m_lvl[4]};
  endfunction

  // ---------------- driver ----------------
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_pins(input bit t, input bit co, input bit me,
                          input bit ca, input bit dr);
    bif.test = t; bif.Comida = co; bif.Medicina = me;
    bif.Carino = ca; bif.Dormir = dr;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_pins(1'($urandom_range(1)), 1'b1, 1'($urandom_range(1)), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_outputs got=%b exp=%b", dut_vec, 7'b0);
      end
    end
    set_pins(0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_settle got=%b exp=%b", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_comida_press();
    int pulses = 0;
    int first  = -1;
    bif.Comida = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL comida_cycle i=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      if (bif.comida_pulse === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL comida_pulse_count got=%0d exp=1", pulses);
    end
    n_cmp++;
    if (first != DC + 1) begin
      n_fail++;
      $display("FAIL comida_pulse_latency got=%0d exp=%0d", first, DC + 1);
    end
    bif.Comida = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
  endtask

  task automatic test_glitch();
    int seen_any = 0;
    for (int i = 0; i < 12; i++) begin
      bif.Medicina = 1'(i % 2 == 0);
      cycle();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL glitch_cycle i=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      if (bif.medicina_pulse !== 1'b0 || dut.level !== 5'b0) seen_any++;
    end
    bif.Medicina = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (bif.medicina_pulse !== 1'b0 || dut.level !== 5'b0) seen_any++;
    end
    n_cmp++;
    if (seen_any != 0) begin
      n_fail++;
      $display("FAIL glitch_rejected got=%0d exp=0", seen_any);
    end
  endtask

  task automatic test_carino_test_mode();
    int hold_at = -1;
    int n_long  = 0;
    int bad_off = 0;
    int fall_at = -1;
    int late    = 0;
    bif.test = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    n_cmp++;
    if (bif.test_lvl !== 1'b1) begin
      n_fail++;
      $display("FAIL test_lvl_on got=%b exp=1", bif.test_lvl);
    end
    bif.Carino = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL carino_cycle i=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      if (hold_at < 0 && bif.carino_hold === 1'b1) hold_at = i;
      if (bif.carino_long === 1'b1) begin
        n_long++;
        if (hold_at < 0 || i == hold_at || (i - hold_at) % LP != 0) bad_off++;
      end
    end
    n_cmp++;
    if (hold_at != DC + 1) begin
      n_fail++;
      $display("FAIL carino_hold_latency got=%0d exp=%0d", hold_at, DC + 1);
    end
    n_cmp++;
    if (bad_off != 0 || n_long != (29 - hold_at) / LP) begin
      n_fail++;
      $display("FAIL carino_long_spacing got=%0d/%0d exp=%0d/0",
               n_long, bad_off, (29 - hold_at) / LP);
    end
    bif.Carino = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL carino_release i=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      if (fall_at < 0 && bif.carino_hold === 1'b0) fall_at = i;
      if (fall_at >= 0 && bif.carino_long !== 1'b0) late++;
    end
    n_cmp++;
    if (fall_at != DC + 1 || late != 0) begin
      n_fail++;
      $display("FAIL carino_release_timing got=%0d/%0d exp=%0d/0", fall_at, late, DC + 1);
    end
    bif.test = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
  endtask

  task automatic test_dormir_normal();
    int last = -1;
    int n_long = 0;
    int bad_gap = 0;
    bif.Dormir = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL dormir_cycle i=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      if (bif.dormir_long === 1'b1) begin
        if (last >= 0 && i - last != TC * LP) bad_gap++;
        last = i;
        n_long++;
      end
    end
    n_cmp++;
    if (n_long < 2 || bad_gap != 0) begin
      n_fail++;
      $display("FAIL dormir_long_gap got=%0d/%0d exp=>=2/0", n_long, bad_gap);
    end
    bif.Dormir = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
  endtask

  task automatic test_simultaneous();
    int co_at = -1;
    int ca_at = -1;
    bif.Comida = 1'b1;
    bif.Carino = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL simul_cycle i=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      if (co_at < 0 && bif.comida_pulse === 1'b1) co_at = i;
      if (ca_at < 0 && bif.carino_hold === 1'b1) ca_at = i;
    end
    n_cmp++;
    if (co_at != ca_at || co_at != DC + 1) begin
      n_fail++;
      $display("FAIL simul_same_cycle got=%0d/%0d exp=%0d", co_at, ca_at, DC + 1);
    end
    set_pins(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle();
  endtask

  task automatic test_reset_mid_hold();
    int waited = 0;
    int hold_at = -1;
    bif.Dormir = 1'b1;
    while (!(m_lvl[4] && m_ticks[1] == 2) && waited < 40) begin
      cycle();
      waited++;
    end
    n_cmp++;
    if (waited >= 40) begin
      n_fail++;
      $display("FAIL midhold_reach got=%0d exp=<40", waited);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_cmp++;
    if (dut_vec !== 7'b0) begin
      n_fail++;
      $display("FAIL midhold_reset got=%b exp=%b", dut_vec, 7'b0);
    end
    for (int i = 0; i < 30; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL midhold_cycle i=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      if (hold_at < 0 && bif.dormir_hold === 1'b1) hold_at = i;
    end
    n_cmp++;
    if (hold_at != DC + 1) begin
      n_fail++;
      $display("FAIL midhold_rehold got=%0d exp=%0d", hold_at, DC + 1);
    end
    bif.Dormir = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
  endtask

  task automatic test_random();
    bit p [5];
    for (int i = 0; i < 5; i++) p[i] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 5; i++) begin
        // mostly long stable stretches, with occasional short glitches
        if ($urandom_range(9) == 0) p[i] = !p[i];
      end
      set_pins(p[0], p[1], p[2], p[3], p[4]);
      cycle();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_cycle c=%0d got=%b exp=%b", c, dut_vec, exp_vec());
      end
    end
    set_pins(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle();
  endtask

  initial begin
    set_pins(0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_comida_press();
    test_glitch();
    test_carino_test_mode();
    test_dormir_normal();
    test_simultaneous();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/botones_mascota.md
# botones_mascota

Input-conditioning front end for the virtual-pet core: takes the four raw action pushbuttons and the test switch from the board, synchronizes and debounces them, and converts them into the event and level signals the need/level state machine consumes. Comida/Medicina become single-cycle press pulses. Carino/Dormir become debounced hold levels plus periodic long-press pulses. The block sits between the board pins and the pet core, on the same clock.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive clocks a synchronized input must disagree with its stable level before the stable level flips. Board builds override it, e.g. 1000000.
- `TICK_CYCLES`, default 5: clocks per hold tick in normal mode.
- `LONG_PRESS_TICKS`, default 15: ticks of continuous hold per long-press pulse. Legal range 1..15.
- `clk`  in  1: single system clock.
- `reset`  in  1: synchronous, active-high; sampled on rising `clk`.
- `test`  in  1: raw test switch, asynchronous.
- `Dormir`, `Comida`, `Medicina`, `Carino`  in  1 each: raw buttons, asynchronous, active-high.
- `test_lvl`  out  1: debounced `test` level.
- `comida_pulse`, `medicina_pulse`  out  1 each: one-clock pulse per debounced press.
- `carino_hold`, `dormir_hold`  out  1 each: debounced button level.
- `carino_long`, `dormir_long`  out  1 each: one-clock pulse every `LONG_PRESS_TICKS` ticks of continuous hold.

## Operation
- **Synchronizer.** Every input passes through a 2-flop synchronizer, yielding `s`. Both flops reset to 0.
- **Debounce FSM.** There is one FSM per input (5 total), with states `IDLE` (stable 0), `RISE_WAIT`, `HELD` (stable 1) and `FALL_WAIT`.
  - `IDLE`: if `s`=1, go to `RISE_WAIT` with cnt=1. Otherwise stay, with cnt=0.
  - `RISE_WAIT`: if `s`=0, return to `IDLE` with cnt=0. Otherwise, if cnt==DEBOUNCE_CYCLES-1, go to `HELD` with cnt=0. Otherwise cnt+1.
  - `HELD` / `FALL_WAIT` mirror this with polarity inverted; `FALL_WAIT` completes to `IDLE`.
  - Stable level = 1 in `HELD` and `FALL_WAIT`, 0 otherwise.
  - `rise` = one-clock registered flag, set on the `RISE_WAIT`->`HELD` transition.
  - The counter width is $clog2(DEBOUNCE_CYCLES+1). It never wraps, because it is cleared on every exit.
- **Press outputs.** `comida_pulse` / `medicina_pulse` = `rise` of their FSM. A held button never re-pulses; release plus a new press is required.
- **Tick generator.** tcnt counts 0..TICK_CYCLES-1 and wraps to 0. `tick`=1 when tcnt==TICK_CYCLES-1. When `test_lvl`=1, `tick`=1 every clock and tcnt is held at 0.
- **Hold counters.** Carino and Dormir each have hcnt, width 4.
  - When the stable level is 0, hcnt=0.
  - When the stable level is 1 and `tick` fires: if hcnt==LONG_PRESS_TICKS-1, pulse `*_long` for one clock and set hcnt=0; otherwise hcnt+1.
- **Simultaneous events.** All buttons are independent; any combination of outputs may assert in the same cycle.
- **Reset.** All FSMs go to `IDLE`, and all counters and outputs go to 0, regardless of pin levels. A button held through reset must complete a full debounce after reset before its hold/pulse output asserts.

## Timing
- Reset value of every output: 0.
- **Press latency.** If raw goes high before edge k and stays high, `s` is 1 after edge k+1. `HELD` is entered at edge k+1+DEBOUNCE_CYCLES. `*_pulse` and `*_hold` are high in the cycle after that edge, and the pulse lasts exactly 1 clock.
- **Glitch rejection.** A raw glitch shorter than DEBOUNCE_CYCLES clocks, as seen at `s`, produces no output change.
- **First long pulse, normal mode.** It occurs LONG_PRESS_TICKS ticks after `*_hold` rises. The first tick counted is the first `tick` at or after the cycle `*_hold` is high, so the delay depends on tcnt phase and is bounded to within TICK_CYCLES clocks.
- **First long pulse, test mode.** It occurs exactly LONG_PRESS_TICKS clocks after `*_hold` rises.
- **Release.** `*_hold` falls DEBOUNCE_CYCLES+2 clocks after raw release. No `*_long` pulse occurs after `*_hold` falls.

## Structure
- **Shared package `botones_pkg`:**
  - 2-bit state encoding: `IDLE`=0, `RISE_WAIT`=1, `HELD`=2, `FALL_WAIT`=3.
  - Hold-counter width constant (4).
- **Sub-module `debounce_fsm`** (parameter `DEBOUNCE_CYCLES`; ports `clk`, `reset`, raw in, `level`, `rise`) contains the synchronizer and the FSM. It is instantiated 5 times.
- **Top** contains the tick generator and both hold counters.

## Test plan
Use defaults: DEBOUNCE_CYCLES=4, TICK_CYCLES=5, LONG_PRESS_TICKS=15, or the override noted.
- Comida raw high for 20 clocks -> `comida_pulse` high exactly 1 clock, 6 clocks after the first sampled-high edge. No second pulse.
- Medicina toggled 1/0/1/0 each clock for 12 clocks -> `medicina_pulse` and all FSM levels stay 0.
- With LONG_PRESS_TICKS=3 and `test`=1 (debounced first), hold Carino 30 clocks -> `carino_hold`=1. `carino_long` pulses 3, 6, 9… clocks after hold rises. After release, `carino_hold` drops 6 clocks later, with no further pulses.
- Normal mode, LONG_PRESS_TICKS=3, Dormir held 60 clocks -> `dormir_long` pulses spaced exactly 15 clocks apart.
- Comida and Carino pressed in the same cycle -> `comida_pulse` and `carino_hold` rise in the same cycle.
- `reset` asserted for 1 clock mid-hold (Dormir held, hcnt=2) -> the next cycle has all outputs 0. `dormir_hold` re-asserts 6 clocks after reset deasserts, and hcnt restarts from 0.
